// File: rtl/frame_pkg.sv
// Shared definitions for the frame header insertion slice.
// Holds the default header ID, header field offsets, the sequence number
// width, the framer state encoding and a helper that packs a header word.
package frame_pkg;

  localparam logic [7:0] HDR_ID_DEFAULT = 8'hA5;

  localparam int unsigned ID_LSB    = 24;
  localparam int unsigned SEQ_LSB   = 8;
  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned SEQ_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // 32-bit header: [31:24] ID, [23:8] sequence number, [7:0] length-1.
  function automatic logic [31:0] build_header(
    input logic [7:0]           id,
    input logic [SEQ_WIDTH-1:0] seq,
    input logic [7:0]           len
  );
    logic [31:0] h;
    h                      = '0;
    h[ID_LSB  +: 8]        = id;
    h[SEQ_LSB +: SEQ_WIDTH] = seq;
    h[LEN_LSB +: 8]        = len;
    return h;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer for a valid/ready stream.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid_i / in_ready_o upstream handshake, in_data_i payload
//   out_valid_o / out_ready_i downstream handshake, out_data_o payload
// Output is fully registered: one cycle from accept to out_valid_o, full
// throughput, and out_data_o held stable while stalled.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             push;

  // Ready depends only on the skid register, so it never combinationally
  // follows out_ready_i.
  assign in_ready_o  = !skid_valid_q;
  assign push        = in_valid_i && !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (!out_valid_q || out_ready_i) begin
      // Output slot frees up: drain the skid entry first to keep order.
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= push;
        if (push) begin
          out_data_q <= in_data_i;
        end
      end
    end else if (push) begin
      // Output stalled: park the incoming word in the skid slot.
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end

endmodule

// File: rtl/frame_header_insert.sv
// Frames an upstream counted sample stream for packet transport.
// Prepends one header word per frame (ID, sequence number, length-1), marks
// the final sample with tlast, and drops samples arriving out of alignment.
// Ports:
//   clk, async_reset_n       clock, asynchronous active-low reset
//   s_axis_*                 upstream sample stream with final_cnt and count
//   cnt_limit                frame length minus 1 (placed in the header)
//   m_axis_*                 framed output; tuser=1 marks the header word
//   sync_err                 pulse: non-zero count dropped while idle
//   seq_err                  pulse: count mismatch inside a frame
//   frame_seq                sequence number of the next header
module frame_header_insert
  import frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  HDR_ID     = HDR_ID_DEFAULT
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_final_cnt,
  input  logic [7:0]            s_axis_count,
  output logic                  s_axis_tready,
  input  logic [7:0]            cnt_limit,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  sync_err,
  output logic                  seq_err,
  output logic [15:0]           frame_seq
);

  localparam int unsigned BW = DATA_WIDTH + 2;

  state_e                 state_q;
  logic [SEQ_WIDTH-1:0]   seq_q;
  logic [7:0]             exp_q;
  logic                   run_q;
  logic                   sync_err_q;
  logic                   seq_err_q;

  logic                   push_hdr;
  logic                   drop;
  logic                   data_acc;
  logic                   buf_in_valid;
  logic                   buf_in_ready;
  logic [BW-1:0]          buf_in_data;
  logic [BW-1:0]          buf_out_data;
  logic [DATA_WIDTH-1:0]  hdr_word;

  always_comb begin
    hdr_word       = '0;
    hdr_word[31:0] = build_header(HDR_ID, seq_q, cnt_limit);

    // run_q keeps tready low while reset is asserted, even if the idle
    // drop condition is present on the inputs.
    push_hdr = run_q && (state_q == ST_IDLE) && s_axis_tvalid &&
               (s_axis_count == 8'd0) && buf_in_ready;
    drop     = run_q && (state_q == ST_IDLE) && s_axis_tvalid &&
               (s_axis_count != 8'd0);
    data_acc = (state_q == ST_DATA) && s_axis_tvalid && buf_in_ready;

    s_axis_tready = drop || ((state_q == ST_DATA) && buf_in_ready);

    // The count==0 beat is not consumed when the header is pushed; it is
    // accepted later as data beat 0.
    buf_in_valid = push_hdr || data_acc;
    buf_in_data  = push_hdr ? {1'b1, 1'b0, hdr_word}
                            : {1'b0, s_axis_final_cnt, s_axis_tdata};
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      exp_q      <= '0;
      run_q      <= 1'b0;
      sync_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      sync_err_q <= drop;
      seq_err_q  <= data_acc && (s_axis_count != exp_q);
      unique case (state_q)
        ST_IDLE: begin
          if (push_hdr) begin
            state_q <= ST_HDR;
          end
        end
        ST_HDR: begin
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (data_acc) begin
            if (s_axis_final_cnt) begin
              seq_q   <= seq_q + 1'b1;
              exp_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              exp_q <= exp_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  axis_skid_buf #(
    .WIDTH (BW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (async_reset_n),
    .in_valid_i  (buf_in_valid),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (buf_in_data),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready),
    .out_data_o  (buf_out_data)
  );

  assign m_axis_tuser = buf_out_data[BW-1];
  assign m_axis_tlast = buf_out_data[BW-2];
  assign m_axis_tdata = buf_out_data[DATA_WIDTH-1:0];
  assign sync_err     = sync_err_q;
  assign seq_err      = seq_err_q;
  assign frame_seq    = seq_q;

endmodule

// File: tb/tb_frame_header_insert.sv
module tb_frame_header_insert;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_final_cnt;
  logic [7:0]    s_axis_count;
  logic          s_axis_tready;
  logic [7:0]    cnt_limit;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          m_axis_tready;
  logic          sync_err;
  logic          seq_err;
  logic [15:0]   frame_seq;

  always #5 clk = ~clk;

  frame_header_insert #(
    .DATA_WIDTH (DW),
    .HDR_ID     (8'hA5)
  ) dut (
    .clk              (clk),
    .async_reset_n    (async_reset_n),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_final_cnt (s_axis_final_cnt),
    .s_axis_count     (s_axis_count),
    .s_axis_tready    (s_axis_tready),
    .cnt_limit        (cnt_limit),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tready    (m_axis_tready),
    .sync_err         (sync_err),
    .seq_err          (seq_err),
    .frame_seq        (frame_seq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected output words {tuser, tlast, tdata}
  logic [33:0] expq[$];
  logic [33:0] obs[$];
  bit          m_in_frame;
  logic [7:0]  m_exp;
  logic [15:0] m_seq;
  int          m_sync, m_seqe;
  int          n_sync, n_seqe;

  bit stall_all = 1'b0;
  bit rand_rdy  = 1'b0;

  task automatic model_beat(input logic [7:0] cnt, input logic fin, input logic [31:0] data,
                            output logic e_sync, output logic e_seq);
    logic [31:0] hdr;
    e_sync = 1'b0;
    e_seq  = 1'b0;
    if (!m_in_frame) begin
      if (cnt != 8'd0) begin
        e_sync = 1'b1;
        m_sync++;
        return;
      end
      hdr = (32'hA5 << 24) | (32'(m_seq) << 8) | 32'(cnt_limit);
      expq.push_back({1'b1, 1'b0, hdr});
      m_in_frame = 1'b1;
      m_exp      = 8'd0;
    end
    if (cnt != m_exp) begin
      e_seq = 1'b1;
      m_seqe++;
    end
    expq.push_back({1'b0, fin, data});
    m_exp = m_exp + 8'd1;
    if (fin) begin
      m_seq      = m_seq + 16'd1;
      m_in_frame = 1'b0;
    end
  endtask

  // Offer one beat, hold it until accepted, then check the error pulses.
  task automatic send(input logic [7:0] cnt, input logic fin, input logic [31:0] data);
    logic e_sync, e_seq;
    bit   ok;
    model_beat(cnt, fin, data, e_sync, e_seq);
    s_axis_tvalid    = 1'b1;
    s_axis_count     = cnt;
    s_axis_final_cnt = fin;
    s_axis_tdata     = data;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      check("sync_err_pulse", 64'(sync_err), 64'(e_sync));
      check("seq_err_pulse", 64'(seq_err), 64'(e_seq));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (expq.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(expq.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    expq.delete();
    obs.delete();
    m_in_frame = 1'b0;
    m_exp      = 8'd0;
    m_seq      = 16'd0;
    m_sync     = 0;
    m_seqe     = 0;
    n_sync     = 0;
    n_seqe     = 0;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    async_reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_m_tdata"},  64'(m_axis_tdata),  64'd0);
    check({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
    check({tag, "_m_tuser"},  64'(m_axis_tuser),  64'd0);
    check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    check({tag, "_sync_err"}, 64'(sync_err),      64'd0);
    check({tag, "_seq_err"},  64'(seq_err),       64'd0);
    check({tag, "_frame_seq"}, 64'(frame_seq),    64'd0);
  endtask

  // Downstream ready generator
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_all) m_axis_tready = 1'b0;
      else if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
      else m_axis_tready = 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, pulse counting
  logic        held_v = 1'b0;
  logic [33:0] held_w;
  always @(negedge clk) begin
    if (!async_reset_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid_held", 64'(m_axis_tvalid), 64'd1);
        check("stall_word_held", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(held_w));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          check("unexpected_word", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'h3_FFFF_FFFF_F);
        end else begin
          check("out_word", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(expq.pop_front()));
        end
        obs.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held_w = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (sync_err) n_sync++;
      if (seq_err) n_seqe++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    async_reset_n    = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = '0;
    s_axis_final_cnt = 1'b0;
    s_axis_count     = 8'd0;
    cnt_limit        = 8'd3;
    clear_model();
    #12;
    check_outputs_zero("reset");
    do_reset();

    // Test 1: two frames of four beats
    cnt_limit = 8'd3;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 4; b++)
        send(8'(b), b == 3, $urandom);
    drain();
    check("t1_words", 64'(obs.size()), 64'd10);
    if (obs.size() == 10) begin
      check("t1_hdr0", 64'(obs[0]), 64'h2_A500_0003);
      check("t1_last0", 64'(obs[4][33:32]), 64'd1);
      check("t1_hdr1", 64'(obs[5]), 64'h2_A500_0103);
      check("t1_last1", 64'(obs[9][33:32]), 64'd1);
    end
    check("t1_sync_cnt", 64'(n_sync), 64'd0);
    check("t1_seq_cnt", 64'(n_seqe), 64'd0);
    check("t1_frame_seq", 64'(frame_seq), 64'd2);

    // Test 2: single-sample frames
    do_reset();
    cnt_limit = 8'd0;
    for (int f = 0; f < 3; f++) send(8'd0, 1'b1, $urandom);
    drain();
    check("t2_words", 64'(obs.size()), 64'd6);
    if (obs.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        check("t2_hdr_flags", 64'(obs[2*i][33:32]), 64'd2);
        check("t2_data_flags", 64'(obs[2*i+1][33:32]), 64'd1);
      end
    end
    check("t2_frame_seq", 64'(frame_seq), 64'd3);

    // Test 3: misaligned idle beats dropped
    do_reset();
    cnt_limit = 8'd1;
    send(8'd2, 1'b0, $urandom);
    send(8'd3, 1'b0, $urandom);
    send(8'd0, 1'b0, $urandom);
    send(8'd1, 1'b1, $urandom);
    drain();
    check("t3_sync_cnt", 64'(n_sync), 64'd2);
    check("t3_words", 64'(obs.size()), 64'd3);
    if (obs.size() > 0) check("t3_hdr", 64'(obs[0]), 64'h2_A500_0001);

    // Test 4: count mismatch inside a frame
    do_reset();
    cnt_limit = 8'd3;
    send(8'd0, 1'b0, $urandom);
    send(8'd1, 1'b0, $urandom);
    send(8'd3, 1'b0, $urandom);
    send(8'd3, 1'b1, $urandom);
    drain();
    check("t4_seq_cnt", 64'(n_seqe), 64'd1);
    check("t4_words", 64'(obs.size()), 64'd5);
    if (obs.size() == 5) check("t4_last", 64'(obs[4][33:32]), 64'd1);

    // Test 5: random backpressure, gaps, occasional stray and bad counts
    do_reset();
    cnt_limit = 8'd7;
    rand_rdy  = 1'b1;
    for (int f = 0; f < 100; f++) begin
      if ($urandom_range(0, 7) == 0) send(8'($urandom_range(1, 7)), 1'b0, $urandom);
      for (int b = 0; b < 8; b++) begin
        c = 8'(b);
        if (b != 0 && $urandom_range(0, 15) == 0) c = 8'($urandom_range(0, 255));
        send(c, b == 7, $urandom);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rand_rdy = 1'b0;
    check("t5_sync_cnt", 64'(n_sync), 64'(m_sync));
    check("t5_seq_cnt", 64'(n_seqe), 64'(m_seqe));
    check("t5_frame_seq", 64'(frame_seq), 64'd100);

    // Test 6: sequence wrap, then reset mid-frame
    do_reset();
    force dut.seq_q = 16'hFFFF;
    #2;
    release dut.seq_q;
    m_seq = 16'hFFFF;
    check("t6_preload", 64'(frame_seq), 64'hFFFF);
    cnt_limit = 8'd1;
    for (int f = 0; f < 2; f++) begin
      send(8'd0, 1'b0, $urandom);
      send(8'd1, 1'b1, $urandom);
    end
    drain();
    check("t6_words", 64'(obs.size()), 64'd6);
    if (obs.size() == 6) begin
      check("t6_hdr_ffff", 64'(obs[0]), 64'h2_A5FF_FF01);
      check("t6_hdr_wrap", 64'(obs[3]), 64'h2_A500_0001);
    end
    check("t6_frame_seq", 64'(frame_seq), 64'd1);

    stall_all = 1'b1;
    cnt_limit = 8'd3;
    @(posedge clk);
    #1;
    send(8'd0, 1'b0, $urandom);
    s_axis_tvalid    = 1'b1;
    s_axis_count     = 8'd1;
    s_axis_final_cnt = 1'b0;
    @(posedge clk);
    #3;
    check("t6_pending_before_reset", 64'(m_axis_tvalid), 64'd1);
    async_reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_midreset");
    clear_model();
    s_axis_tvalid = 1'b0;
    stall_all     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset_n = 1'b1;
    @(posedge clk);
    #1;
    cnt_limit = 8'd0;
    send(8'd0, 1'b1, $urandom);
    drain();
    check("t6_post_words", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      check("t6_post_hdr", 64'(obs[0]), 64'h2_A500_0000);
      check("t6_post_last", 64'(obs[1][33:32]), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
